// File: rtl/vecmac_accum.sv
// Streaming 4-lane dot-product accumulator: lane-sum stage, wrapping accumulator
// with beat counting, and a 2-entry result FIFO with a sticky drop flag.
module vecmac_accum #(
   parameter int ACC_W = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [63:0]      in_product,
   input  logic             in_last,
   input  logic             clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_beats,
   output logic             out_ovf,
   output logic             drop_err
);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t state, state_next;

   logic             s1_valid;
   logic             s1_last;
   logic [17:0]      s1_lsum;
   logic [17:0]      lane_sum;

   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;

   logic [ACC_W:0]   sum_ext;
   logic [CNT_W-1:0] cnt_inc;
   logic             cnt_sat;
   logic             ovf_new;

   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             push_ok;
   logic             drop;

   logic [ACC_W-1:0] fifo_sum   [2];
   logic [CNT_W-1:0] fifo_beats [2];
   logic             fifo_ovf   [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;

   assign lane_sum = 18'(in_product[15:0])  + 18'(in_product[31:16])
                   + 18'(in_product[47:32]) + 18'(in_product[63:48]);

   // Stage 1: a beat arriving together with clr is never loaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_lsum  <= '0;
      end else begin
         s1_valid <= in_valid & ~clr;
         s1_last  <= in_last;
         s1_lsum  <= lane_sum;
      end
   end

   assign sum_ext = {1'b0, acc} + (ACC_W+1)'(s1_lsum);
   assign cnt_sat = (cnt == {CNT_W{1'b1}});
   assign cnt_inc = cnt_sat ? cnt : cnt + CNT_W'(1);
   assign ovf_new = ovf | sum_ext[ACC_W] | cnt_sat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (clr) begin
         state_next = IDLE;
      end else if (s1_valid) begin
         case (state)
            IDLE:    state_next = s1_last ? IDLE : ACCUM;
            ACCUM:   state_next = s1_last ? IDLE : ACCUM;
            default: state_next = IDLE;
         endcase
      end
   end

   // A last beat in stage 2 pushes even when clr is high in the same cycle.
   always_comb begin
      push      = s1_valid & s1_last;
      pop       = (count != 2'd0) & out_ready;
      fifo_full = (count == 2'd2);
      push_ok   = push & (~fifo_full | pop);
      drop      = push & fifo_full & ~pop;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (clr || push) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (s1_valid) begin
         acc <= sum_ext[ACC_W-1:0];
         cnt <= cnt_inc;
         ovf <= ovf_new;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            fifo_sum[i]   <= '0;
            fifo_beats[i] <= '0;
            fifo_ovf[i]   <= 1'b0;
         end
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         count    <= 2'd0;
         drop_err <= 1'b0;
      end else begin
         if (push_ok) begin
            fifo_sum[wr_ptr]   <= sum_ext[ACC_W-1:0];
            fifo_beats[wr_ptr] <= cnt_inc;
            fifo_ovf[wr_ptr]   <= ovf_new;
            wr_ptr             <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push_ok, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         if (drop) drop_err <= 1'b1;
      end
   end

   assign out_valid = (count != 2'd0);
   assign out_sum   = out_valid ? fifo_sum[rd_ptr]   : '0;
   assign out_beats = out_valid ? fifo_beats[rd_ptr] : '0;
   assign out_ovf   = out_valid ? fifo_ovf[rd_ptr]   : 1'b0;

endmodule

// File: tb/tb_vecmac_accum.sv
// Bench for vecmac_accum: directed scenarios plus random traffic against a
// transaction-level model (true integer sums, result queue, sticky drop flag).
module tb_vecmac_accum;

   localparam int    ACC_W = 18;
   localparam int    CNT_W = 4;
   localparam longint MOD  = 64'd1 << ACC_W;
   localparam int    MAXC  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic [63:0]      in_product;
   logic             in_last;
   logic             clr;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0] out_beats;
   logic             out_ovf;
   logic             drop_err;

   vecmac_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_product(in_product),
      .in_last(in_last), .clr(clr), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_beats(out_beats), .out_ovf(out_ovf), .drop_err(drop_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint sum;
      int     beats;
      bit     ovf;
   } result_t;

   result_t q[$];
   longint  p_total;
   int      p_beats;
   bit      m_s1_v, m_s1_last;
   longint  m_s1_lsum;
   bit      m_drop;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      p_total   = 0;
      p_beats   = 0;
      m_s1_v    = 0;
      m_s1_last = 0;
      m_s1_lsum = 0;
      m_drop    = 0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_valid"}, out_valid, q.size() > 0);
      if (q.size() > 0) begin
         check({tag, "_sum"},   out_sum,   q[0].sum);
         check({tag, "_beats"}, out_beats, q[0].beats);
         check({tag, "_ovf"},   out_ovf,   q[0].ovf);
      end
      check({tag, "_drop"}, drop_err, m_drop);
   endtask

   // One clock: check current outputs, apply inputs, advance model and DUT.
   task automatic cycle(input bit v, input logic [63:0] prod, input bit last,
                        input bit c, input bit rdy, input string tag);
      bit      pop;
      bit      have;
      result_t r;
      check_outputs(tag);
      in_valid   = v;
      in_product = prod;
      in_last    = last;
      clr        = c;
      out_ready  = rdy;
      pop  = (q.size() > 0) && rdy;
      have = 0;
      if (m_s1_v) begin
         if (c && !m_s1_last) begin
            p_total = 0;
            p_beats = 0;
         end else begin
            p_total += m_s1_lsum;
            p_beats++;
            if (m_s1_last) begin
               r.sum   = p_total % MOD;
               r.beats = (p_beats > MAXC) ? MAXC : p_beats;
               r.ovf   = (p_total >= MOD) || (p_beats > MAXC);
               have    = 1;
               p_total = 0;
               p_beats = 0;
            end
         end
      end
      if (c) begin
         p_total = 0;
         p_beats = 0;
      end
      if (pop) void'(q.pop_front());
      if (have) begin
         if (q.size() < 2) q.push_back(r);
         else              m_drop = 1;
      end
      m_s1_v    = v && !c;
      m_s1_last = last;
      m_s1_lsum = longint'(prod[15:0]) + longint'(prod[31:16])
                + longint'(prod[47:32]) + longint'(prod[63:48]);
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [63:0] lanes(input int p3, input int p2, input int p1, input int p0);
      return {p3[15:0], p2[15:0], p1[15:0], p0[15:0]};
   endfunction

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, rdy, "idle");
   endtask

   initial begin
      rst_n = 0; in_valid = 0; in_product = '0; in_last = 0; clr = 0; out_ready = 0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_sum",   out_sum,   0);
      check("rst_beats", out_beats, 0);
      check("rst_ovf",   out_ovf,   0);
      check("rst_drop",  drop_err,  0);
      rst_n = 1;

      // Single beat, 2-cycle latency
      cycle(1, lanes(4, 3, 2, 1), 1, 0, 1, "t1_beat");
      check("t1_lat1", out_valid, 0);
      cycle(0, '0, 0, 0, 1, "t1_wait");
      check("t1_valid", out_valid, 1);
      check("t1_sum",   out_sum,   10);
      check("t1_beats", out_beats, 1);
      check("t1_ovf",   out_ovf,   0);
      idle(2, 1);

      // Three beats
      cycle(1, lanes(65025, 65025, 65025, 65025), 0, 0, 1, "t2_b0");
      cycle(1, lanes(1, 1, 1, 1), 0, 0, 1, "t2_b1");
      cycle(1, lanes(0, 0, 0, 0), 1, 0, 1, "t2_b2");
      cycle(0, '0, 0, 0, 1, "t2_wait");
      check("t2_sum",   out_sum,   260104);
      check("t2_beats", out_beats, 3);
      check("t2_ovf",   out_ovf,   0);
      idle(2, 1);

      // Accumulator wrap at ACC_W=18
      cycle(1, lanes(65025, 65025, 65025, 65025), 0, 0, 1, "t3_b0");
      cycle(1, lanes(65025, 65025, 65025, 65025), 1, 0, 1, "t3_b1");
      cycle(0, '0, 0, 0, 1, "t3_wait");
      check("t3_sum", out_sum, 258056);
      check("t3_ovf", out_ovf, 1);
      idle(2, 1);

      // Backpressure: third result dropped
      cycle(1, lanes(0, 0, 0, 5), 1, 0, 0, "t4_b5");
      cycle(1, lanes(0, 0, 0, 6), 1, 0, 0, "t4_b6");
      cycle(1, lanes(0, 0, 0, 7), 1, 0, 0, "t4_b7");
      idle(2, 0);
      check("t4_head", out_sum, 5);
      check("t4_drop", drop_err, 1);
      cycle(0, '0, 0, 0, 1, "t4_pop5");
      check("t4_next", out_sum, 6);
      cycle(0, '0, 0, 0, 1, "t4_pop6");
      check("t4_empty", out_valid, 0);
      idle(1, 1);

      // clr aborts partial accumulation
      cycle(1, lanes(1, 1, 1, 1), 0, 0, 1, "t5_b0");
      cycle(1, lanes(1, 1, 1, 1), 0, 0, 1, "t5_b1");
      cycle(0, '0, 0, 1, 1, "t5_clr");
      cycle(1, lanes(2, 2, 2, 2), 1, 0, 1, "t5_b2");
      cycle(0, '0, 0, 0, 1, "t5_wait");
      check("t5_sum",   out_sum,   8);
      check("t5_beats", out_beats, 1);
      idle(2, 1);

      // Asynchronous reset mid-accumulation with a result queued
      cycle(1, lanes(0, 0, 0, 3), 1, 0, 0, "t6_q");
      cycle(1, lanes(9, 9, 9, 9), 0, 0, 0, "t6_b0");
      cycle(1, lanes(9, 9, 9, 9), 0, 0, 0, "t6_b1");
      check("t6_queued", out_valid, 1);
      in_valid = 0;
      #2 rst_n = 0;
      #1;
      check("t6_rst_valid", out_valid, 0);
      check("t6_rst_drop",  drop_err,  0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      cycle(1, lanes(0, 0, 0, 1), 1, 0, 1, "t6_beat");
      cycle(0, '0, 0, 0, 1, "t6_wait");
      check("t6_sum",   out_sum,   1);
      check("t6_beats", out_beats, 1);
      idle(2, 1);

      // Random traffic, including long results to reach counter saturation
      for (int i = 0; i < 1500; i++) begin
         bit          v, last, c, rdy;
         logic [63:0] p;
         v    = ($urandom_range(0, 3) != 0);
         last = (i % 300 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0);
         c    = ($urandom_range(0, 40) == 0);
         rdy  = ($urandom_range(0, 2) != 0);
         for (int l = 0; l < 4; l++)
            p[l*16 +: 16] = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(60000, 65535))
                                                       : 16'($urandom);
         cycle(v, p, last, c, rdy, "rnd");
      end
      idle(4, 1);
      check_outputs("final");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
